// File: rtl/id_ex_if.sv
// ID/EX pipeline register bundle: decode-side inputs, execute-side registered outputs.
// The slave modport is the register itself; the master modport is the surrounding datapath.
interface id_ex_if #(
   parameter int DATA_W = 32,
   parameter int REG_AW = 5,
   parameter int CNT_W  = 16
);
   logic [2:0]        ex_in;
   logic [2:0]        m_in;
   logic [1:0]        wb_in;
   logic              id_valid;
   logic [DATA_W-1:0] pc4_in;
   logic [DATA_W-1:0] rs_data_in;
   logic [DATA_W-1:0] rt_data_in;
   logic [DATA_W-1:0] imm_in;
   logic [REG_AW-1:0] rs_in;
   logic [REG_AW-1:0] rt_in;
   logic [REG_AW-1:0] rd_in;
   logic              stall_in;
   logic              flush;

   logic [2:0]        ex_out;
   logic [2:0]        m_out;
   logic [1:0]        wb_out;
   logic              ex_valid;
   logic [DATA_W-1:0] pc4_q;
   logic [DATA_W-1:0] rs_data_q;
   logic [DATA_W-1:0] rt_data_q;
   logic [DATA_W-1:0] imm_q;
   logic [REG_AW-1:0] rs_q;
   logic [REG_AW-1:0] rt_q;
   logic [REG_AW-1:0] rd_q;
   logic              hazard_stall;
   logic [CNT_W-1:0]  bubble_cnt;

   modport master (
      output ex_in, m_in, wb_in, id_valid, pc4_in, rs_data_in, rt_data_in, imm_in,
             rs_in, rt_in, rd_in, stall_in, flush,
      input  ex_out, m_out, wb_out, ex_valid, pc4_q, rs_data_q, rt_data_q, imm_q,
             rs_q, rt_q, rd_q, hazard_stall, bubble_cnt
   );

   modport slave (
      input  ex_in, m_in, wb_in, id_valid, pc4_in, rs_data_in, rt_data_in, imm_in,
             rs_in, rt_in, rd_in, stall_in, flush,
      output ex_out, m_out, wb_out, ex_valid, pc4_q, rs_data_q, rt_data_q, imm_q,
             rs_q, rt_q, rd_q, hazard_stall, bubble_cnt
   );
endinterface

// File: rtl/id_ex_stage_reg.sv
// ID/EX pipeline register with hold, bubble insertion and a saturating bubble counter.
// Define ID_EX_HAZARD_EN to build in load-use detection (hazard_stall); otherwise it is tied to 0.
module id_ex_stage_reg #(
   parameter int DATA_W = 32,
   parameter int REG_AW = 5,
   parameter int CNT_W  = 16
) (
   input  logic     clk,
   input  logic     rst_n,
   id_ex_if.slave   bus
);

   logic [2:0]        r_ex_p1;
   logic [2:0]        r_m_p1;
   logic [1:0]        r_wb_p1;
   logic              r_vld_p1;
   logic [DATA_W-1:0] r_pc4_p1;
   logic [DATA_W-1:0] r_rs_data_p1;
   logic [DATA_W-1:0] r_rt_data_p1;
   logic [DATA_W-1:0] r_imm_p1;
   logic [REG_AW-1:0] r_rs_p1;
   logic [REG_AW-1:0] r_rt_p1;
   logic [REG_AW-1:0] r_rd_p1;
   logic [CNT_W-1:0]  r_bubble_cnt;

   logic w_hazard;
   logic w_bubble;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
      return (c == {CNT_W{1'b1}}) ? c : c + CNT_W'(1);
   endfunction

`ifdef ID_EX_HAZARD_EN
   // Uses only registered state plus decode register numbers, so no loop through the control unit.
   assign w_hazard = r_vld_p1 & r_m_p1[1] & (r_rt_p1 != '0) & bus.id_valid &
                     ((r_rt_p1 == bus.rs_in) | (r_rt_p1 == bus.rt_in));
`else
   assign w_hazard = 1'b0;
`endif

   assign w_bubble = bus.flush | w_hazard;

   // ID -> EX boundary
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_ex_p1      <= '0;
         r_m_p1       <= '0;
         r_wb_p1      <= '0;
         r_vld_p1     <= 1'b0;
         r_pc4_p1     <= '0;
         r_rs_data_p1 <= '0;
         r_rt_data_p1 <= '0;
         r_imm_p1     <= '0;
         r_rs_p1      <= '0;
         r_rt_p1      <= '0;
         r_rd_p1      <= '0;
         r_bubble_cnt <= '0;
      end else if (!bus.stall_in) begin
         if (w_bubble) begin
            r_ex_p1      <= '0;
            r_m_p1       <= '0;
            r_wb_p1      <= '0;
            r_vld_p1     <= 1'b0;
            r_bubble_cnt <= sat_inc(r_bubble_cnt);
         end else begin
            r_ex_p1  <= bus.ex_in & {3{bus.id_valid}};
            r_m_p1   <= bus.m_in  & {3{bus.id_valid}};
            r_wb_p1  <= bus.wb_in & {2{bus.id_valid}};
            r_vld_p1 <= bus.id_valid;
         end
         // Operands travel even through a bubble; only control is squashed.
         r_pc4_p1     <= bus.pc4_in;
         r_rs_data_p1 <= bus.rs_data_in;
         r_rt_data_p1 <= bus.rt_data_in;
         r_imm_p1     <= bus.imm_in;
         r_rs_p1      <= bus.rs_in;
         r_rt_p1      <= bus.rt_in;
         r_rd_p1      <= bus.rd_in;
      end
   end

   assign bus.ex_out       = r_ex_p1;
   assign bus.m_out        = r_m_p1;
   assign bus.wb_out       = r_wb_p1;
   assign bus.ex_valid     = r_vld_p1;
   assign bus.pc4_q        = r_pc4_p1;
   assign bus.rs_data_q    = r_rs_data_p1;
   assign bus.rt_data_q    = r_rt_data_p1;
   assign bus.imm_q        = r_imm_p1;
   assign bus.rs_q         = r_rs_p1;
   assign bus.rt_q         = r_rt_p1;
   assign bus.rd_q         = r_rd_p1;
   assign bus.hazard_stall = w_hazard;
   assign bus.bubble_cnt   = r_bubble_cnt;

endmodule
